// File: rtl/mem_traffic_gen.sv
// Stimulus/checker stage for the SDRAM controller: requests init, then runs four
// write/read-back phases and reports pass/fail, error count and first failing address.
module mem_traffic_gen #(
  parameter int unsigned N_PH0        = 1,
  parameter int unsigned N_PH1        = 2,
  parameter int unsigned N_PH2        = 8,
  parameter int unsigned N_PH3        = 8,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] INIT_TIMEOUT = 32'd20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        we,
  output logic        re,
  output logic [21:0] addr,
  output logic [15:0] data_in,
  output logic        init_start,
  output logic [3:0]  phase_start,
  output logic        done,
  output logic        busy,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [21:0] first_err_addr
);

  typedef enum logic [3:0] {
    IDLE, INIT_WAIT, PH_START, W_ISSUE, W_GAP, W_WAIT,
    R_ISSUE, R_GAP, R_DATA, R_WAIT, NEXT, FINISH
  } state_t;

  state_t      state, state_next;
  logic [1:0]  phase, phase_next;
  logic [7:0]  idx, idx_next, idx_inc, n_cur;
  logic [31:0] tcnt, tcnt_next;
  logic        armed;
  logic [21:0] cur_addr;
  logic [15:0] cur_data;
  logic [7:0]  err_inc;

  logic        we_next, re_next, init_start_next, done_next, busy_next, pass_next;
  logic [21:0] addr_next, first_err_addr_next;
  logic [15:0] data_in_next;
  logic [3:0]  phase_start_next;
  logic [7:0]  err_cnt_next;

  always_comb begin
    cur_addr = {14'b0, idx};
    n_cur    = 8'(N_PH0);
    case (phase)
      2'd0: begin
        cur_addr = {14'b0, idx};
        n_cur    = 8'(N_PH0);
      end
      2'd1: begin
        cur_addr = {2'b00, 12'h000, 8'h10 + idx};
        n_cur    = 8'(N_PH1);
      end
      2'd2: begin
        cur_addr = {idx[1:0], 12'h100 + {6'b0, idx[7:2]}, 8'h00};
        n_cur    = 8'(N_PH2);
      end
      default: begin
        cur_addr = {2'b11, 12'hFFF - {4'b0, idx}, 8'hFF - idx};
        n_cur    = 8'(N_PH3);
      end
    endcase
    cur_data = cur_addr[15:0] ^ 16'h5A5A ^ {phase, 14'b0};
    idx_inc  = idx + 8'd1;
    err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  always_comb begin
    state_next          = state;
    phase_next          = phase;
    idx_next            = idx;
    tcnt_next           = tcnt;
    we_next             = 1'b0;
    re_next             = 1'b0;
    init_start_next     = 1'b0;
    phase_start_next    = '0;
    done_next           = 1'b0;
    addr_next           = addr;
    data_in_next        = data_in;
    busy_next           = busy;
    pass_next           = pass;
    err_cnt_next        = err_cnt;
    first_err_addr_next = first_err_addr;

    case (state)
      IDLE: begin
        // armed blocks a start sampled on the first edge after reset release
        if (start && armed) begin
          err_cnt_next        = '0;
          first_err_addr_next = '0;
          pass_next           = 1'b0;
          busy_next           = 1'b1;
          init_start_next     = 1'b1;
          tcnt_next           = '0;
          state_next          = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        tcnt_next = tcnt + 32'd1;
        if (tcnt != 32'd0 && ready) begin
          phase_next = 2'd0;
          state_next = PH_START;
        end else if (tcnt == INIT_TIMEOUT - 32'd1) begin
          err_cnt_next        = 8'd1;
          first_err_addr_next = '0;
          state_next          = FINISH;
        end
      end
      PH_START: begin
        phase_start_next = 4'b0001 << phase;
        idx_next         = '0;
        state_next       = (n_cur == 8'd0) ? NEXT : W_ISSUE;
      end
      W_ISSUE: begin
        if (ready) begin
          we_next      = 1'b1;
          addr_next    = cur_addr;
          data_in_next = cur_data;
          state_next   = W_GAP;
        end
      end
      W_GAP: state_next = W_WAIT;
      W_WAIT: begin
        if (ready) begin
          if (idx_inc == n_cur) begin
            idx_next   = '0;
            state_next = R_ISSUE;
          end else begin
            idx_next   = idx_inc;
            state_next = W_ISSUE;
          end
        end
      end
      R_ISSUE: begin
        if (ready) begin
          re_next    = 1'b1;
          addr_next  = cur_addr;
          state_next = R_GAP;
        end
      end
      R_GAP: begin
        tcnt_next  = '0;
        state_next = R_DATA;
      end
      R_DATA: begin
        tcnt_next = tcnt + 32'd1;
        if (data_out_valid) begin
          if (data_out != cur_data) begin
            err_cnt_next = err_inc;
            if (err_cnt == 8'd0) first_err_addr_next = addr;
          end
          state_next = R_WAIT;
        end else if (tcnt == 32'(TIMEOUT - 1)) begin
          err_cnt_next = err_inc;
          if (err_cnt == 8'd0) first_err_addr_next = addr;
          state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (ready) begin
          if (idx_inc == n_cur) begin
            state_next = NEXT;
          end else begin
            idx_next   = idx_inc;
            state_next = R_ISSUE;
          end
        end
      end
      NEXT: begin
        if (phase == 2'd3) begin
          state_next = FINISH;
        end else begin
          phase_next = phase + 2'd1;
          state_next = PH_START;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        pass_next  = (err_cnt == 8'd0);
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      phase          <= '0;
      idx            <= '0;
      tcnt           <= '0;
      armed          <= 1'b0;
      we             <= 1'b0;
      re             <= 1'b0;
      addr           <= '0;
      data_in        <= '0;
      init_start     <= 1'b0;
      phase_start    <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_next;
      phase          <= phase_next;
      idx            <= idx_next;
      tcnt           <= tcnt_next;
      armed          <= 1'b1;
      we             <= we_next;
      re             <= re_next;
      addr           <= addr_next;
      data_in        <= data_in_next;
      init_start     <= init_start_next;
      phase_start    <= phase_start_next;
      done           <= done_next;
      busy           <= busy_next;
      pass           <= pass_next;
      err_cnt        <= err_cnt_next;
      first_err_addr <= first_err_addr_next;
    end
  end

endmodule
